// File: rtl/event_pkg.sv
// Shared definitions for the event dispatcher slice: default widths,
// message field offsets and the dispatcher FSM state encoding.
// No logic; imported by the interface, the arbiter and the top level.
package event_pkg;

  localparam int DEF_NUM_CORE = 4;
  localparam int DEF_MSG_WID  = 32;
  localparam int DEF_TIME_WID = 16;
  localparam int DEF_WINDOW   = 64;

  // Message layout: timestamp in the low bits, LP field right above it.
  localparam int TIME_LSB = 0;
  localparam int LP_LSB   = DEF_TIME_WID;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2
  } state_t;

endpackage

// File: rtl/event_dispatcher_if.sv
// Bundle of every dispatcher-facing signal: queue pop/insert, core
// request/ack and event broadcast, monitor bus, core_active, min_time.
// master = dispatcher side, slave = queue/cores/monitor side.
interface event_dispatcher_if
  import event_pkg::*;
#(
  parameter int NUM_CORE = DEF_NUM_CORE,
  parameter int MSG_WID  = DEF_MSG_WID,
  parameter int TIME_WID = DEF_TIME_WID
);
  localparam int IDW = $clog2(NUM_CORE);

  // event priority queue
  logic [MSG_WID-1:0]          q_deq_msg;
  logic                        q_deq_vld;
  logic                        q_deq_pop;
  logic [MSG_WID-1:0]          q_enq_msg;
  logic                        q_enq_vld;
  logic                        q_enq_rdy;
  // processing cores
  logic [NUM_CORE*MSG_WID-1:0] core_req_msg;
  logic [NUM_CORE-1:0]         core_req_vld;
  logic [NUM_CORE-1:0]         core_req_last;
  logic [NUM_CORE-1:0]         core_req_ack;
  logic [MSG_WID-1:0]          core_evt_msg;
  logic [NUM_CORE-1:0]         core_evt_vld;
  // core monitor
  logic [MSG_WID-1:0]          mon_msg;
  logic                        mon_sent_vld;
  logic                        mon_rcv_vld;
  logic [IDW-1:0]              mon_core_id;
  logic [NUM_CORE-1:0]         core_active;
  logic [TIME_WID-1:0]         min_time;
  logic                        min_time_vld;

  modport master (
    input  q_deq_msg, q_deq_vld, q_enq_rdy,
    input  core_req_msg, core_req_vld, core_req_last,
    input  min_time, min_time_vld,
    output q_deq_pop, q_enq_msg, q_enq_vld,
    output core_req_ack, core_evt_msg, core_evt_vld,
    output mon_msg, mon_sent_vld, mon_rcv_vld, mon_core_id, core_active
  );

  modport slave (
    output q_deq_msg, q_deq_vld, q_enq_rdy,
    output core_req_msg, core_req_vld, core_req_last,
    output min_time, min_time_vld,
    input  q_deq_pop, q_enq_msg, q_enq_vld,
    input  core_req_ack, core_evt_msg, core_evt_vld,
    input  mon_msg, mon_sent_vld, mon_rcv_vld, mon_core_id, core_active
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first requester at or after ptr (mod NUM_CORE).
// Latency: purely combinational. Backpressure: none, caller decides use.
// Ports: req/ptr in; grant_onehot, grant_idx, grant_vld out.
module rr_arbiter
  import event_pkg::*;
#(
  parameter int NUM_CORE = DEF_NUM_CORE
) (
  input  logic [NUM_CORE-1:0]         req,
  input  logic [$clog2(NUM_CORE)-1:0] ptr,
  output logic [NUM_CORE-1:0]         grant_onehot,
  output logic [$clog2(NUM_CORE)-1:0] grant_idx,
  output logic                        grant_vld
);
  localparam int IDW = $clog2(NUM_CORE);

  logic [IDW-1:0] cand;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    // NUM_CORE is a power of two, so the IDW-bit add wraps modulo NUM_CORE.
    for (int i = 0; i < NUM_CORE; i++) begin
      cand = ptr + IDW'(i);
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    grant_onehot = grant_vld ? (NUM_CORE'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/event_dispatcher.sv
// Pops queue events to idle cores; routes core returns to queue or monitor.
// Latency: decision in IDLE, strobes 1 cycle later; one txn per 2 cycles.
// Backpressure: non-last returns wait on q_enq_rdy; dispatch waits on a free core and the time window.
// Ports: clk, reset (async, active-high), bus (event_dispatcher_if.master).
module event_dispatcher
  import event_pkg::*;
#(
  parameter int NUM_CORE = DEF_NUM_CORE,
  parameter int MSG_WID  = DEF_MSG_WID,
  parameter int TIME_WID = DEF_TIME_WID,
  parameter int WINDOW   = DEF_WINDOW
) (
  input logic                clk,
  input logic                reset,
  event_dispatcher_if.master bus
);
  localparam int IDW = $clog2(NUM_CORE);

  state_t              state;
  logic [IDW-1:0]      rr_ptr;
  logic [IDW-1:0]      lat_idx;
  logic                lat_last;

  logic [NUM_CORE-1:0] elig;
  logic [NUM_CORE-1:0] grant_onehot;
  logic [IDW-1:0]      grant_idx;
  logic                grant_vld;
  logic [MSG_WID-1:0]  grant_msg;
  logic                grant_last;

  logic                free_vld;
  logic [IDW-1:0]      free_idx;
  logic [TIME_WID-1:0] evt_time;
  logic [TIME_WID:0]   limit;
  logic                window_ok;
  logic                dispatch_ok;

  // Completions bypass queue backpressure; generated events need room.
  assign elig = bus.core_req_vld & (bus.core_req_last | {NUM_CORE{bus.q_enq_rdy}});

  rr_arbiter #(.NUM_CORE(NUM_CORE)) u_arb (
    .req          (elig),
    .ptr          (rr_ptr),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .grant_vld    (grant_vld)
  );

  always_comb begin
    grant_msg = '0;
    for (int c = 0; c < NUM_CORE; c++) begin
      if (grant_onehot[c]) grant_msg = bus.core_req_msg[c*MSG_WID +: MSG_WID];
    end
  end
  assign grant_last = |(grant_onehot & bus.core_req_last);

  // Lowest-index idle core: scan downwards so the last hit is the lowest.
  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = NUM_CORE - 1; i >= 0; i--) begin
      if (!bus.core_active[i]) begin
        free_vld = 1'b1;
        free_idx = IDW'(i);
      end
    end
  end

  // One extra bit so min_time near the top of the range cannot wrap the limit.
  assign evt_time    = bus.q_deq_msg[TIME_LSB +: TIME_WID];
  assign limit       = {1'b0, bus.min_time} + (TIME_WID+1)'(WINDOW);
  assign window_ok   = !bus.min_time_vld || ({1'b0, evt_time} < limit);
  assign dispatch_ok = bus.q_deq_vld && free_vld && window_ok;

  // Combinational handshakes, only in the IDLE decision cycle.
  assign bus.core_req_ack = (!reset && state == IDLE && grant_vld) ? grant_onehot : '0;
  assign bus.q_deq_pop    = !reset && state == IDLE && !grant_vld && dispatch_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      lat_idx          <= '0;
      lat_last         <= 1'b0;
      bus.core_active  <= '0;
      bus.q_enq_vld    <= 1'b0;
      bus.q_enq_msg    <= '0;
      bus.core_evt_vld <= '0;
      bus.core_evt_msg <= '0;
      bus.mon_sent_vld <= 1'b0;
      bus.mon_rcv_vld  <= 1'b0;
      bus.mon_msg      <= '0;
      bus.mon_core_id  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            rr_ptr   <= grant_idx + IDW'(1);
            lat_idx  <= grant_idx;
            lat_last <= grant_last;
            if (grant_last) begin
              bus.mon_rcv_vld <= 1'b1;
              bus.mon_msg     <= grant_msg;
              bus.mon_core_id <= grant_idx;
            end else begin
              bus.q_enq_vld   <= 1'b1;
              bus.q_enq_msg   <= grant_msg;
            end
            state <= RECV;
          end else if (dispatch_ok) begin
            // core_active is set here so it is already visible during SEND.
            bus.core_active[free_idx] <= 1'b1;
            bus.core_evt_vld <= NUM_CORE'(1) << free_idx;
            bus.core_evt_msg <= bus.q_deq_msg;
            bus.mon_sent_vld <= 1'b1;
            bus.mon_msg      <= bus.q_deq_msg;
            bus.mon_core_id  <= free_idx;
            state            <= SEND;
          end
        end
        SEND: begin
          bus.core_evt_vld <= '0;
          bus.mon_sent_vld <= 1'b0;
          state            <= IDLE;
        end
        RECV: begin
          bus.q_enq_vld   <= 1'b0;
          bus.mon_rcv_vld <= 1'b0;
          if (lat_last) bus.core_active[lat_idx] <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_event_dispatcher.sv
// Directed bench for event_dispatcher with a transaction scoreboard.
// Expected queue inserts / monitor strobes are queued at the decision cycle
// and matched against the DUT when the strobes appear.
module tb_event_dispatcher;
  import event_pkg::*;

  localparam int NC = 4;
  localparam int MW = 32;
  localparam int TW = 16;

  typedef enum int {K_ENQ, K_SENT, K_RCV} kind_t;
  typedef struct {
    kind_t         kind;
    int            core;
    logic [MW-1:0] msg;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  event_dispatcher_if #(.NUM_CORE(NC), .MSG_WID(MW), .TIME_WID(TW)) bus ();

  event_dispatcher #(.NUM_CORE(NC), .MSG_WID(MW), .TIME_WID(TW), .WINDOW(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [MW-1:0] mk(input logic [15:0] lp, input logic [15:0] t);
    return (MW'(lp) << LP_LSB) | (MW'(t) << TIME_LSB);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_tx(input kind_t k, input int c, input logic [MW-1:0] m);
    exp_t e;
    e.kind = k;
    e.core = c;
    e.msg  = m;
    sb.push_back(e);
  endtask

  task automatic take(input kind_t k, input int core, input logic [MW-1:0] msg);
    exp_t e;
    chk("sb_pending", 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_kind", 64'(k), 64'(e.kind));
      chk("sb_msg", msg, e.msg);
      if (k != K_ENQ) chk("sb_core", 64'(core), 64'(e.core));
      if (k == K_SENT) begin
        chk("evt_vld", bus.core_evt_vld, 64'(1) << e.core);
        chk("evt_msg", bus.core_evt_msg, e.msg);
      end
    end
  endtask

  // Runs at every falling edge: strobe exclusivity plus scoreboard match.
  task automatic observe();
    int n;
    n = int'(bus.q_enq_vld) + int'(bus.mon_sent_vld) + int'(bus.mon_rcv_vld) + int'(bus.q_deq_pop);
    chk("one_strobe", 64'(n <= 1), 64'd1);
    if (bus.q_enq_vld)    take(K_ENQ, 0, bus.q_enq_msg);
    if (bus.mon_sent_vld) take(K_SENT, int'(bus.mon_core_id), bus.mon_msg);
    if (bus.mon_rcv_vld)  take(K_RCV, int'(bus.mon_core_id), bus.mon_msg);
  endtask

  task automatic half();
    @(negedge clk);
    observe();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_pop"},      bus.q_deq_pop,    0);
    chk({tag, "_enq_vld"},  bus.q_enq_vld,    0);
    chk({tag, "_enq_msg"},  bus.q_enq_msg,    0);
    chk({tag, "_ack"},      bus.core_req_ack, 0);
    chk({tag, "_evt_vld"},  bus.core_evt_vld, 0);
    chk({tag, "_evt_msg"},  bus.core_evt_msg, 0);
    chk({tag, "_mon_msg"},  bus.mon_msg,      0);
    chk({tag, "_sent"},     bus.mon_sent_vld, 0);
    chk({tag, "_rcv"},      bus.mon_rcv_vld,  0);
    chk({tag, "_core_id"},  bus.mon_core_id,  0);
    chk({tag, "_active"},   bus.core_active,  0);
  endtask

  // Head event -> free core: pop in the decision cycle, SEND the next.
  task automatic dispatch_one(input logic [MW-1:0] m, input int core, input logic [NC-1:0] act);
    bus.q_deq_msg = m;
    bus.q_deq_vld = 1'b1;
    half();
    chk("pop", bus.q_deq_pop, 1);
    expect_tx(K_SENT, core, m);
    adv();
    bus.q_deq_vld = 1'b0;
    half();
    chk("active_in_send", bus.core_active, act);
    adv();
  endtask

  initial begin
    reset             = 1'b1;
    bus.q_deq_msg     = '0;
    bus.q_deq_vld     = 1'b0;
    bus.q_enq_rdy     = 1'b1;
    bus.core_req_msg  = '0;
    bus.core_req_vld  = '0;
    bus.core_req_last = '0;
    bus.min_time      = '0;
    bus.min_time_vld  = 1'b0;

    // Reset state
    half();
    reset_check("reset");
    adv();
    adv();
    reset = 1'b0;

    // Head time 5, nothing active -> core 0
    dispatch_one(mk(16'h000A, 16'd5), 0, 4'b0001);

    // Cores 1 and 3 return non-last together; ptr 0 -> core 1 then core 3
    bus.core_req_msg[1*MW +: MW] = mk(16'h0001, 16'h0111);
    bus.core_req_msg[3*MW +: MW] = mk(16'h0003, 16'h0333);
    bus.core_req_vld = 4'b1010;
    half();
    chk("rr_ack_core1", bus.core_req_ack, 4'b0010);
    expect_tx(K_ENQ, 1, mk(16'h0001, 16'h0111));
    adv();
    bus.core_req_vld = 4'b1000;
    half();
    chk("ack_quiet_in_recv", bus.core_req_ack, 0);
    adv();
    half();
    chk("rr_ack_core3", bus.core_req_ack, 4'b1000);
    expect_tx(K_ENQ, 3, mk(16'h0003, 16'h0333));
    adv();
    bus.core_req_vld = '0;
    half();
    adv();

    // Pointer wrapped to 0: cores 0 and 3 together -> core 0 first
    bus.core_req_msg[0*MW +: MW] = mk(16'h0000, 16'h0100);
    bus.core_req_msg[3*MW +: MW] = mk(16'h0003, 16'h0300);
    bus.core_req_vld = 4'b1001;
    half();
    chk("rr_wrap_core0", bus.core_req_ack, 4'b0001);
    expect_tx(K_ENQ, 0, mk(16'h0000, 16'h0100));
    adv();
    bus.core_req_vld = 4'b1000;
    half();
    adv();
    half();
    chk("rr_then_core3", bus.core_req_ack, 4'b1000);
    expect_tx(K_ENQ, 3, mk(16'h0003, 16'h0300));
    adv();
    bus.core_req_vld = '0;
    half();
    adv();

    // Fill cores 1 and 2
    dispatch_one(mk(16'h000A, 16'd6), 1, 4'b0011);
    dispatch_one(mk(16'h000A, 16'd7), 2, 4'b0111);

    // Core 2 completes while the queue is full: still serviced
    bus.q_enq_rdy = 1'b0;
    bus.core_req_msg[2*MW +: MW] = mk(16'h0002, 16'h0222);
    bus.core_req_last = 4'b0100;
    bus.core_req_vld  = 4'b0100;
    half();
    chk("last_ack_core2", bus.core_req_ack, 4'b0100);
    expect_tx(K_RCV, 2, mk(16'h0002, 16'h0222));
    adv();
    bus.core_req_vld  = '0;
    bus.core_req_last = '0;
    half();
    chk("active_held_in_recv", bus.core_active, 4'b0111);
    chk("no_enq_on_last", bus.q_enq_vld, 0);
    adv();
    half();
    chk("active_cleared", bus.core_active, 4'b0011);
    adv();

    // Non-last return stalls while the queue is full
    bus.core_req_msg[1*MW +: MW] = mk(16'h0001, 16'h0555);
    bus.core_req_vld = 4'b0010;
    half();
    chk("stall_no_ack", bus.core_req_ack, 0);
    adv();
    bus.q_enq_rdy = 1'b1;
    half();
    chk("stall_release_ack", bus.core_req_ack, 4'b0010);
    expect_tx(K_ENQ, 1, mk(16'h0001, 16'h0555));
    adv();
    bus.core_req_vld = '0;
    half();
    adv();

    // Window: min 100 + 64 -> 164 blocked, 163 dispatched
    bus.min_time     = 16'd100;
    bus.min_time_vld = 1'b1;
    bus.q_deq_msg    = mk(16'h000B, 16'd164);
    bus.q_deq_vld    = 1'b1;
    half();
    chk("win_164_blocked", bus.q_deq_pop, 0);
    adv();
    half();
    chk("win_164_still_idle", bus.q_deq_pop, 0);
    adv();
    dispatch_one(mk(16'h000B, 16'd163), 2, 4'b0111);

    // Limit near the top of the range must not wrap: FFF0+64 = 0x10030
    bus.min_time = 16'hFFF0;
    dispatch_one(mk(16'h000C, 16'h0040), 3, 4'b1111);

    // All cores busy: dispatch blocked, completion still serviced
    bus.min_time_vld = 1'b0;
    bus.q_deq_msg    = mk(16'h000D, 16'd10);
    bus.q_deq_vld    = 1'b1;
    half();
    chk("full_no_pop", bus.q_deq_pop, 0);
    adv();
    bus.core_req_msg[0*MW +: MW] = mk(16'h0000, 16'h0777);
    bus.core_req_last = 4'b0001;
    bus.core_req_vld  = 4'b0001;
    half();
    chk("full_ack_core0", bus.core_req_ack, 4'b0001);
    chk("recv_beats_pop", bus.q_deq_pop, 0);
    expect_tx(K_RCV, 0, mk(16'h0000, 16'h0777));
    adv();
    bus.core_req_vld  = '0;
    bus.core_req_last = '0;
    half();
    adv();
    half();
    chk("redispatch_pop", bus.q_deq_pop, 1);
    adv();

    // Reset lands in the SEND cycle: the send is dropped
    reset         = 1'b1;
    bus.q_deq_vld = 1'b0;
    half();
    reset_check("mid_send");
    adv();
    reset = 1'b0;
    half();
    chk("post_reset_active", bus.core_active, 0);
    adv();
    half();
    adv();

    chk("sb_drained", 64'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/event_dispatcher.md
# event_dispatcher

Sits between the event priority queue, the processing cores and the core monitor. Pops events from the queue and sends each one to an idle core. Collects the messages the cores return: generated events go back into the queue, and the completion message goes to the monitor. Serialises all traffic onto a single monitor bus (msg, core_id, sent/rcv strobes) and owns the core-active vector. Throttles dispatch with an optimistic time window above the monitor's minimum active timestamp.

## Interface
Parameters:
- NUM_CORE, 4, number of cores; power of two, ≥2
- MSG_WID, 32, message width; bits [TIME_WID-1:0] carry the event timestamp
- TIME_WID, 16, timestamp width
- WINDOW, 64, dispatch window above min_time, in timestamp units

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- q_deq_msg  in  MSG_WID  head-of-queue event
- q_deq_vld  in  1  queue non-empty
- q_deq_pop  out  1  pop strobe, one cycle
- q_enq_msg  out  MSG_WID  event to insert into the queue
- q_enq_vld  out  1  insert strobe
- q_enq_rdy  in  1  queue can accept an insert this cycle
- core_req_msg  in  NUM_CORE*MSG_WID  per-core return message, core c at [c*MSG_WID +: MSG_WID]
- core_req_vld  in  NUM_CORE  per-core return request
- core_req_last  in  NUM_CORE  return is the completion message
- core_req_ack  out  NUM_CORE  one-hot grant, one cycle
- core_evt_msg  out  MSG_WID  event broadcast to the cores
- core_evt_vld  out  NUM_CORE  one-hot: core c takes core_evt_msg
- mon_msg  out  MSG_WID  monitor message bus
- mon_sent_vld  out  1  monitor strobe for a dispatched event
- mon_rcv_vld  out  1  monitor strobe for a completion
- mon_core_id  out  $clog2(NUM_CORE)  core index on the monitor bus
- core_active  out  NUM_CORE  cores currently holding an event
- min_time  in  TIME_WID  minimum timestamp among active cores, from the monitor
- min_time_vld  in  1  min_time is meaningful

## Operation
- FSM states: IDLE, SEND, RECV.
- SEND and RECV each last exactly one cycle and always return to IDLE.
- Decisions are made only in IDLE. Priority order:
  - (1) receive
  - (2) dispatch
  - (3) stay in IDLE
- Receive eligibility: core c is eligible if core_req_vld[c] && (core_req_last[c] || q_enq_rdy).
  - A non-last return stalls (is not acked) while q_enq_rdy=0.
  - Completions never wait on the queue.
- Receive grant: the rr_arbiter picks the first eligible core at or after rr_ptr, modulo NUM_CORE.
  - core_req_ack[c] pulses combinationally in the IDLE cycle.
  - The message and the last flag are latched.
  - rr_ptr <= (c+1) mod NUM_CORE.
  - Next state is RECV.
- RECV with last=0: q_enq_vld=1, q_enq_msg=latched msg. No monitor strobe.
- RECV with last=1: mon_rcv_vld=1, mon_msg=latched msg, mon_core_id=c. No queue insert. core_active[c] clears at the end of RECV.
- Dispatch condition: no receive is eligible, q_deq_vld=1, core_active≠all-ones, and the window check passes.
- Window check:
  - limit = {1'b0,min_time} + WINDOW, computed in TIME_WID+1 bits (no wrap).
  - Passes if !min_time_vld or {1'b0,event_time} < limit.
- Dispatch grant: the target core is the lowest-index core with core_active=0.
  - q_deq_pop pulses combinationally in the IDLE cycle.
  - The message and the core index are latched.
  - Next state is SEND.
- SEND cycle:
  - core_evt_vld[c]=1, core_evt_msg=msg.
  - mon_sent_vld=1, mon_msg=msg, mon_core_id=c.
  - core_active[c]=1 is already visible during SEND.
- mon_sent_vld and mon_rcv_vld are never high in the same cycle.
- At most one of q_enq_vld, q_deq_pop, or a SEND/RECV strobe set is active per cycle.
- A core returning with core_active[c]=0 is still serviced; a last=1 return in that case leaves core_active unchanged.

## Timing
- Reset (asynchronous): state=IDLE, rr_ptr=0, core_active=0, all strobes and acks 0, all message and id outputs 0.
- Reset mid-SEND or mid-RECV aborts the transaction. The latched message is dropped, with no strobe after reset.
- Latency from decision to strobe is 1 cycle. Peak throughput is one transaction per 2 cycles.
- core_req_msg and core_req_vld must hold until ack.
- q_deq_msg must be valid in the pop cycle.
- When all cores are active, dispatch is blocked and returns are still serviced.
- q_deq_vld=0 or a failing window check leaves the FSM in IDLE indefinitely without side effects.

## Structure
- Shared package event_pkg holds:
  - the message field offsets: TIME_LSB=0 and the LP field at TIME_WID
  - the state enum
  - default widths
- Sub-module rr_arbiter(NUM_CORE): inputs req, ptr; outputs grant_onehot, grant_idx, grant_vld. Purely combinational.
- FSM, latches, core_active and the window compare live in the top level.

## Test plan
- Reset release, q_deq_vld=1, msg time=5, no cores active → pop at T, SEND at T+1 to core 0; core_active=0001; mon_sent_vld=1, mon_core_id=0.
- Cores 1 and 3 request simultaneously with last=0, rr_ptr=0 → core 1 acked first and enqueued; core 3 acked 2 cycles later; rr_ptr=0 afterwards.
- Core 2 active, returns last=1 while q_enq_rdy=0 → acked; mon_rcv_vld=1, mon_core_id=2; q_enq_vld=0; core_active[2]=0 after RECV.
- min_time=100, min_time_vld=1, WINDOW=64, head time=164 → no pop; head time=163 → dispatched.
- min_time=16'hFFF0, head time=16'h0005 → passes (17-bit compare, no wrap).
- All 4 cores active plus a pending head event; core 0 completes → RECV, then dispatch to core 0 two cycles later. Assert reset during the following SEND → all outputs 0, no strobe.
